instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4: instruction queue entries, power of two, 2..16.
REQ-002 SHALL have parameter RESET_PC, default 64'h0: first fetch address after reset.
REQ-003 SHALL have clk  in  1: single clock; all state updates on rising edge.
REQ-004 SHALL have rst  in  1: reset, asynchronous, active-low.
REQ-005 SHALL have imem_req_valid  out  1: fetch request valid.
REQ-006 SHALL have imem_req_ready  in  1: memory accepts request.
REQ-007 SHALL have imem_req_addr  out  64: fetch byte address.
REQ-008 SHALL have imem_rsp_valid  in  1: instruction response valid.
REQ-009 SHALL have imem_rsp_data  in  32: instruction word.
REQ-010 SHALL have out_valid  out  1: instruction available to the decode/execute stage.
REQ-011 SHALL have out_ready  in  1: consumer takes instruction.
REQ-012 SHALL have out_instr  out  32: instruction at queue head.
REQ-013 SHALL have out_pc  out  64: address of out_instr.
REQ-014 SHALL have redirect_valid  in  1: branch taken or control-flow change.
REQ-015 SHALL have redirect_pc  in  64: new fetch address.

Function
REQ-016 SHALL have two states: IDLE (first cycle after reset release, no requests) and FETCH; IDLE->FETCH unconditionally, FETCH held until reset.
REQ-017 SHALL assert imem_req_valid in FETCH only when occupancy + live_outstanding < DEPTH (credit rule); an accepted response never finds the queue full.
REQ-018 SHALL count a request as accepted when imem_req_valid && imem_req_ready; fetch_pc then advances by 4 (64-bit wrap at 2^64).
REQ-019 SHALL hold imem_req_addr stable while imem_req_valid=1 and imem_req_ready=0, unless redirect_valid.
REQ-020 SHALL treat responses as in-order, latency >= 1 cycle, unbounded; each valid response pops one outstanding entry.
REQ-021 SHALL push live responses into the queue with their PC (a FIFO of request PCs travels with outstanding requests).
REQ-022 SHALL present out_valid=1 whenever queue non-empty; head pops on out_valid && out_ready.
REQ-023 SHALL support push and pop in the same cycle at any occupancy, including empty (no bypass: push to empty queue appears next cycle) and full.
REQ-024 SHALL on redirect_valid: flush queue (out_valid=0 next cycle), set fetch_pc=redirect_pc, mark all outstanding requests stale; first new request issues the next cycle.
REQ-025 SHALL count a request accepted in the redirect cycle as stale; its address is the pre-redirect fetch_pc.
REQ-026 SHALL discard stale responses, including one arriving in the redirect cycle; a stale-drop counter decrements per discarded response.
REQ-027 SHALL let a pop in the redirect cycle complete (consumer owns that instruction) before the flush.
REQ-028 SHALL treat redirect_valid in IDLE as setting fetch_pc only.
REQ-029 SHALL never issue more than DEPTH requests outstanding (live + stale counted together for PC-FIFO capacity).

Reset
REQ-030 SHALL on rst=0 asynchronously: state=IDLE, fetch_pc=RESET_PC, queue empty, outstanding=0, stale=0, imem_req_valid=0, out_valid=0, out_instr=0, out_pc=0, imem_req_addr=RESET_PC.
REQ-031 SHALL on reset mid-operation discard all queued and outstanding instructions; responses arriving during reset are ignored.

Structure
REQ-032 SHALL place state enum (IDLE, FETCH), INSTR_W=32, ADDR_W=64, PC_STEP=4 in shared package cpu_pkg.
REQ-033 SHALL instantiate one sub-module fetch_fifo (parameterised width/depth, push/pop/full/empty/count), used for both instruction queue and outstanding-PC FIFO.

Verification
REQ-034 Reset release, imem_req_ready=1, 1-cycle latency, out_ready=1 -> addresses 0,4,8,... issued; out_pc 0,4,8 in order, first out_valid 3 cycles after release.
REQ-035 out_ready=0, DEPTH=4 -> exactly 4 requests accepted, imem_req_valid then 0; out_ready=1 for one cycle -> one pop, one new request at 0x10.
REQ-036 3 requests outstanding, redirect_pc=0x100 -> 3 responses dropped, next out_pc=0x100, no instruction from 0x0..0x8 delivered.
REQ-037 Redirect and response in same cycle, plus pop -> popped instruction delivered, response dropped, queue empty next cycle.
REQ-038 imem_req_ready=0 for 5 cycles -> imem_req_addr constant; random response latency 1..8 -> out_pc strictly +4 sequential.
REQ-039 rst=0 asserted mid-stream between edges -> outputs at reset values immediately; restart fetches from RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-path types and constants: widths, PC step, FSM state encoding,
// and the packed entry carried by the instruction queue.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 64;

    localparam logic [ADDR_W-1:0] PC_STEP = 64'd4;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } iq_entry_t;

    // Sequential fetch address; wraps naturally at 2^64.
    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-unit bundle: instruction memory request/response, decode-side output
// and control-flow redirect. master = fetch unit, slave = memory/consumer side.
interface instr_fetch_if;
    import cpu_pkg::*;

    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [ADDR_W-1:0]  imem_req_addr;

    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;

    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;

    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready,
        output redirect_valid,
        output redirect_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// Power-of-two synchronous FIFO with occupancy count and synchronous flush.
// Push is accepted when full only if a pop happens in the same cycle.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: entries are only visible through count/pointers.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: credit-limited in-order requests, PC FIFO for
// outstanding requests, instruction queue to decode, redirect with stale drop.
//
//   state | meaning
//   IDLE  | first cycle after reset release, no requests issued
//   FETCH | issuing requests under credit, accepting responses, delivering
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);

    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned ENTRY_W = $bits(iq_entry_t);

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic [CNT_W-1:0]  stale_q;
    logic [CNT_W-1:0]  stale_d;

    logic [CNT_W-1:0]  iq_count;
    logic [CNT_W-1:0]  pcq_count;
    logic [CNT_W-1:0]  live_cnt;
    logic [CNT_W:0]    credit_sum;
    logic [CNT_W:0]    pcq_after;
    logic              iq_full;
    logic              iq_empty;
    logic              pcq_full;
    logic              pcq_empty;
    logic [ADDR_W-1:0] pcq_head;
    iq_entry_t         iq_head;
    iq_entry_t         iq_push_entry;

    logic              in_fetch;
    logic              credit_ok;
    logic              req_valid;
    logic              req_fire;
    logic              redirect_fetch;
    logic              rsp_fire;
    logic              rsp_stale;
    logic              rsp_live;
    logic              out_valid;
    logic              out_fire;

    assign in_fetch       = (state_q == FETCH);
    assign redirect_fetch = in_fetch && bus.redirect_valid;

    // Stale entries are always the oldest in the PC FIFO because responses are in order.
    assign live_cnt   = pcq_count - stale_q;
    assign credit_sum = {1'b0, iq_count} + {1'b0, live_cnt};
    assign credit_ok  = (credit_sum < (CNT_W+1)'(DEPTH)) && !pcq_full && !iq_full;

    always_comb begin
        state_d   = state_q;
        req_valid = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                req_valid = credit_ok;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign req_fire  = req_valid && bus.imem_req_ready;
    assign rsp_fire  = in_fetch && bus.imem_rsp_valid && !pcq_empty;
    assign rsp_stale = rsp_fire && (bus.redirect_valid || (stale_q != '0));
    assign rsp_live  = rsp_fire && !rsp_stale;

    // On redirect everything still in flight after this edge becomes stale,
    // including a request accepted in the redirect cycle itself.
    assign pcq_after = {1'b0, pcq_count} + (CNT_W+1)'(req_fire) - (CNT_W+1)'(rsp_fire);

    always_comb begin
        stale_d = stale_q;
        if (redirect_fetch) begin
            stale_d = CNT_W'(pcq_after);
        end else if (rsp_stale) begin
            stale_d = stale_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            stale_q    <= '0;
        end else begin
            stale_q <= stale_d;
            if (bus.redirect_valid) begin
                fetch_pc_q <= bus.redirect_pc;
            end else if (req_fire) begin
                fetch_pc_q <= next_pc(fetch_pc_q);
            end
        end
    end

    fetch_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (DEPTH)
    ) u_pc_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (req_fire),
        .push_data (fetch_pc_q),
        .pop       (rsp_fire),
        .head      (pcq_head),
        .full      (pcq_full),
        .empty     (pcq_empty),
        .count     (pcq_count)
    );

    assign iq_push_entry.pc    = pcq_head;
    assign iq_push_entry.instr = bus.imem_rsp_data;

    // Flush wins over the pop; the consumer still takes the head this cycle.
    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_instr_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_fetch),
        .push      (rsp_live),
        .push_data (iq_push_entry),
        .pop       (out_fire),
        .head      (iq_head),
        .full      (iq_full),
        .empty     (iq_empty),
        .count     (iq_count)
    );

    assign out_valid = !iq_empty;
    assign out_fire  = out_valid && bus.out_ready;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.out_valid      = out_valid;
    assign bus.out_instr      = out_valid ? iq_head.instr : '0;
    assign bus.out_pc         = out_valid ? iq_head.pc : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: in-order memory model with configurable
// latency, and a scoreboard of expected (pc, instr) pairs checked on each pop.
module tb_instr_fetch;
    import cpu_pkg::*;

    localparam int          DEPTH  = 4;
    localparam logic [63:0] RST_PC = 64'h0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_if bus ();

    instr_fetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } mem_t;

    exp_t        exp_q[$];
    mem_t        mem_q[$];
    logic [63:0] fired[$];
    logic [63:0] popped[$];

    int          checks   = 0;
    int          errors   = 0;
    int          cyc      = 0;
    int          fire_cnt = 0;
    int          lat_min  = 1;
    int          lat_max  = 1;
    logic [63:0] model_pc = RST_PC;
    logic        hold_pend = 1'b0;
    logic [63:0] hold_addr = '0;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'hC0DE_5A17;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // In-order instruction memory: one response per cycle once its due cycle is reached.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (!rst) begin
            mem_q.delete();
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
        end else if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = instr_of(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
        end
    end

    // Monitor/scoreboard: sees the values that the next rising edge will register.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            model_pc  = RST_PC;
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) chk("addr_hold", bus.imem_req_addr, hold_addr);
            if (bus.out_valid && bus.out_ready) begin
                popped.push_back(bus.out_pc);
                chk("pop_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    chk("out_pc", bus.out_pc, exp_q[0].pc);
                    chk("out_instr", 64'(bus.out_instr), 64'(exp_q[0].instr));
                    void'(exp_q.pop_front());
                end
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                chk("req_addr", bus.imem_req_addr, model_pc);
                fired.push_back(bus.imem_req_addr);
                fire_cnt++;
                mem_q.push_back('{addr: bus.imem_req_addr,
                                  due: cyc + int'($urandom_range(lat_max, lat_min))});
            end
            if (bus.redirect_valid) begin
                exp_q.delete();
                model_pc = bus.redirect_pc;
            end else if (bus.imem_req_valid && bus.imem_req_ready) begin
                exp_q.push_back('{pc: bus.imem_req_addr, instr: instr_of(bus.imem_req_addr)});
                model_pc = model_pc + 64'd4;
            end
            hold_pend = bus.imem_req_valid && !bus.imem_req_ready && !bus.redirect_valid;
            hold_addr = bus.imem_req_addr;
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        tick(3);
        fired.delete();
        popped.delete();
        fire_cnt = 0;
    endtask

    initial begin
        logic [63:0] a0;
        int n;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
        a0 = '0;
        n = 0;
    end

    initial begin
        logic [63:0] a0;
        int n;
        bus.imem_req_ready = 1'b0;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;

        // Reset values
        do_reset();
        chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        chk("rst_req_addr", bus.imem_req_addr, RST_PC);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_instr", 64'(bus.out_instr), 64'd0);
        chk("rst_out_pc", bus.out_pc, 64'd0);

        // Streaming, 1-cycle latency, consumer always ready
        bus.imem_req_ready = 1'b1;
        bus.out_ready      = 1'b1;
        lat_min = 1; lat_max = 1;
        rst = 1'b1;
        chk("idle_no_req", 64'(bus.imem_req_valid), 64'd0);
        tick(1);
        chk("first_req_valid", 64'(bus.imem_req_valid), 64'd1);
        chk("first_req_addr", bus.imem_req_addr, RST_PC);
        chk("t1_out_valid_e1", 64'(bus.out_valid), 64'd0);
        tick(1);
        chk("t1_out_valid_e2", 64'(bus.out_valid), 64'd0);
        tick(1);
        chk("t1_out_valid_e3", 64'(bus.out_valid), 64'd1);
        chk("t1_out_pc_e3", bus.out_pc, 64'h0);
        tick(12);
        chk("t1_pops", 64'(popped.size() >= 8), 64'd1);
        chk("t1_pc1", popped[1], 64'h4);
        chk("t1_pc2", popped[2], 64'h8);

        // Credit limit with a stalled consumer
        do_reset();
        bus.imem_req_ready = 1'b1;
        bus.out_ready      = 1'b0;
        rst = 1'b1;
        tick(12);
        chk("t2_fire_cnt", 64'(fire_cnt), 64'd4);
        chk("t2_req_blocked", 64'(bus.imem_req_valid), 64'd0);
        chk("t2_out_valid", 64'(bus.out_valid), 64'd1);
        chk("t2_head_pc", bus.out_pc, 64'h0);
        bus.out_ready = 1'b1;
        tick(1);
        bus.out_ready = 1'b0;
        tick(3);
        chk("t2_fire_cnt_after_pop", 64'(fire_cnt), 64'd5);
        chk("t2_new_addr", fired[fired.size()-1], 64'h10);
        chk("t2_one_pop", 64'(popped.size()), 64'd1);
        chk("t2_req_blocked_again", 64'(bus.imem_req_valid), 64'd0);

        // Redirect with three requests outstanding
        do_reset();
        lat_min = 8; lat_max = 8;
        bus.imem_req_ready = 1'b1;
        bus.out_ready      = 1'b1;
        rst = 1'b1;
        n = 0;
        while (fire_cnt < 3 && n < 20) begin
            tick(1);
            n++;
        end
        chk("t3_three_fired", 64'(fire_cnt), 64'd3);
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h100;
        tick(1);
        bus.redirect_valid = 1'b0;
        bus.imem_req_ready = 1'b1;
        chk("t3_req_valid", 64'(bus.imem_req_valid), 64'd1);
        chk("t3_req_addr", bus.imem_req_addr, 64'h100);
        chk("t3_out_valid", 64'(bus.out_valid), 64'd0);
        tick(30);
        chk("t3_pops", 64'(popped.size() != 0), 64'd1);
        chk("t3_first_pc", popped[0], 64'h100);

        // Redirect, stale response and pop in the same cycle
        do_reset();
        lat_min = 1; lat_max = 1;
        bus.imem_req_ready = 1'b1;
        bus.out_ready      = 1'b0;
        rst = 1'b1;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        chk("t4_out_valid", 64'(bus.out_valid), 64'd1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h200;
        bus.out_ready      = 1'b1;
        tick(1);
        bus.redirect_valid = 1'b0;
        bus.out_ready      = 1'b0;
        chk("t4_flushed", 64'(bus.out_valid), 64'd0);
        chk("t4_one_pop", 64'(popped.size()), 64'd1);
        chk("t4_popped_pc", popped[0], 64'h0);
        bus.out_ready = 1'b1;
        tick(10);
        chk("t4_pops", 64'(popped.size() >= 2), 64'd1);
        chk("t4_next_pc", popped[1], 64'h200);

        // Address hold under backpressure, then random latency/backpressure
        lat_min = 1; lat_max = 8;
        bus.imem_req_ready = 1'b0;
        tick(1);
        a0 = bus.imem_req_addr;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("t5_hold_valid", 64'(bus.imem_req_valid), 64'd1);
            chk("t5_hold_addr", bus.imem_req_addr, a0);
        end
        popped.delete();
        for (int i = 0; i < 80; i++) begin
            bus.imem_req_ready = ($urandom_range(3, 0) != 0);
            bus.out_ready      = ($urandom_range(2, 0) != 0);
            tick(1);
        end
        bus.imem_req_ready = 1'b1;
        bus.out_ready      = 1'b1;
        tick(20);
        chk("t5_pops", 64'(popped.size() > 10), 64'd1);
        for (int i = 1; i < popped.size(); i++) begin
            chk("t5_pc_seq", popped[i], popped[i-1] + 64'd4);
        end

        // Asynchronous reset between edges, then restart from RESET_PC
        lat_min = 1; lat_max = 1;
        tick(5);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("t6_req_valid", 64'(bus.imem_req_valid), 64'd0);
        chk("t6_req_addr", bus.imem_req_addr, RST_PC);
        chk("t6_out_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_out_instr", 64'(bus.out_instr), 64'd0);
        chk("t6_out_pc", bus.out_pc, 64'd0);
        tick(2);
        fired.delete();
        popped.delete();
        fire_cnt = 0;
        rst = 1'b1;
        tick(10);
        chk("t6_fired_any", 64'(fired.size() != 0), 64'd1);
        chk("t6_first_addr", fired[0], RST_PC);
        chk("t6_pops", 64'(popped.size() >= 2), 64'd1);
        chk("t6_first_pc", popped[0], RST_PC);
        chk("t6_second_pc", popped[1], RST_PC + 64'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
